// File: rtl/iob_cache_be_mem.sv
// -----------------------------------------------------------------------------
// iob_cache_be_mem
//
// Native-interface memory responder for the cache back-end. A request is
// captured from IDLE or RESP, held for L cycles (WAIT), then acknowledged for
// exactly one cycle (RESP). Backing store is a 2**MEM_ADDR_W x DATA_W array
// with per-byte write strobes. The array itself is never reset.
//
// Optional feature (compile-time macro IOB_CACHE_BE_MEM_RANDLAT_EN):
//   when defined, L = LATENCY + lfsr[2:0] where lfsr is an 8-bit LFSR
//   (x^8+x^6+x^5+x^4+1, reset 8'hA5) that steps once per capture.
//   When undefined, L = LATENCY and no LFSR exists.
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst    in   asynchronous active-low reset
//   req    in   request from cache back-end
//   addr   in   byte address (ADDR_W)
//   wdata  in   write data (DATA_W)
//   wstrb  in   byte strobes (DATA_W/8); all zero means read
//   rdata  out  read data, valid during the ack cycle, held otherwise
//   ack    out  one-cycle acknowledge (high exactly in RESP)
//   idle   out  high when no request is pending
// -----------------------------------------------------------------------------
module iob_cache_be_mem #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int LATENCY    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ack,
    output logic                idle
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    // Wide enough for LATENCY (max 15) plus the optional random extra (max 7).
    localparam int CNT_W  = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic                  run;
    logic [MEM_ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    logic [DATA_W-1:0]     mem [0:(2**MEM_ADDR_W)-1];

    logic [CNT_W-1:0]      lat;
    logic                  lat_one;
    logic                  capture;
    logic                  enter_resp;
    logic                  use_in;
    logic [MEM_ADDR_W-1:0] idx_in;
    logic [MEM_ADDR_W-1:0] eff_idx;
    logic [DATA_W-1:0]     eff_wdata;
    logic [STRB_W-1:0]     eff_strb;
    logic                  eff_wr;
    logic                  unused_addr;

    // Upper address bits alias and byte-offset bits are don't-care.
    assign idx_in      = addr[MEM_ADDR_W+OFF_W-1:OFF_W];
    assign unused_addr = ^addr;

`ifdef IOB_CACHE_BE_MEM_RANDLAT_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;

    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign lat     = CNT_W'(LATENCY) + CNT_W'(lfsr[2:0]);

    // Latency for this capture is taken from the current value; step after.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         lfsr <= 8'hA5;
        else if (capture) lfsr <= {lfsr[6:0], lfsr_fb};
    end
`else
    assign lat = CNT_W'(LATENCY);
`endif

    assign lat_one = (lat == CNT_W'(1));

    // run keeps the block from accepting (and, with L=1, writing memory for)
    // a request sampled while reset is still asserted.
    assign capture    = run && req && ((state == S_IDLE) || (state == S_RESP));
    assign enter_resp = (capture && lat_one) ||
                        ((state == S_WAIT) && (cnt == CNT_W'(1)));

    // With L=1 the transaction enters RESP on its own capture edge, so the
    // live inputs are used; otherwise the registered copy is used.
    assign use_in    = capture && lat_one;
    assign eff_idx   = use_in ? idx_in : idx_q;
    assign eff_wdata = use_in ? wdata  : wdata_q;
    assign eff_strb  = use_in ? wstrb  : wstrb_q;
    assign eff_wr    = |eff_strb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run <= 1'b0;
        else      run <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_RESP: begin
                    if (capture) begin
                        idx_q   <= idx_in;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        cnt     <= lat - CNT_W'(1);
                        state   <= lat_one ? S_RESP : S_WAIT;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    // Inputs are deliberately not looked at here.
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // rdata only changes on the edge entering RESP, so it holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            rdata <= '0;
        else if (enter_resp) rdata <= eff_wr ? '0 : mem[eff_idx];
    end

    // Write commits on the edge entering RESP. An aborted transaction never
    // gets there because reset forces the state back to IDLE.
    always_ff @(posedge clk) begin
        if (enter_resp && eff_wr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (eff_strb[b]) mem[eff_idx][b*8 +: 8] <= eff_wdata[b*8 +: 8];
            end
        end
    end

    assign ack  = (state == S_RESP);
    assign idle = (state == S_IDLE) || ((state == S_RESP) && !req);

endmodule

// File: tb/tb_iob_cache_be_mem.sv
module tb_iob_cache_be_mem;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       req;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][3:0]  wstrb;
  logic [1:0]       ack, idle;

  iob_cache_be_mem #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .LATENCY(LAT0)) u_mem0 (
    .clk(clk), .rst(rst), .req(req[0]), .addr(addr[0]), .wdata(wdata[0]),
    .wstrb(wstrb[0]), .rdata(rdata[0]), .ack(ack[0]), .idle(idle[0])
  );

  iob_cache_be_mem #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .LATENCY(LAT1)) u_mem1 (
    .clk(clk), .rst(rst), .req(req[1]), .addr(addr[1]), .wdata(wdata[1]),
    .wstrb(wstrb[1]), .rdata(rdata[1]), .ack(ack[1]), .idle(idle[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: one word array per instance, one latency LFSR per instance.
  logic [31:0] mdl [2][1024];
  logic [7:0]  lfsr_ref [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic next_lat(input int sel, output int l);
    int base;
    base = (sel == 0) ? LAT0 : LAT1;
`ifdef IOB_CACHE_BE_MEM_RANDLAT_EN
    l = base + int'(lfsr_ref[sel] % 8);
    lfsr_ref[sel] = {lfsr_ref[sel][6:0], ^(lfsr_ref[sel] & 8'hB8)};
`else
    l = base;
`endif
  endtask

  task automatic drive_garbage(input int sel);
    req[sel]   = 1'($urandom);
    addr[sel]  = $urandom;
    wdata[sel] = $urandom;
    wstrb[sel] = 4'($urandom);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ack", ack[s], 0);
      chk("rst_rdata", rdata[s], 0);
      chk("rst_idle", idle[s], 1);
    end
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
    lfsr_ref[0] = 8'hA5;
    lfsr_ref[1] = 8'hA5;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("post_rst_ack", ack[s], 0);
      chk("post_rst_rdata", rdata[s], 0);
      chk("post_rst_idle", idle[s], 1);
    end
    repeat (2) @(negedge clk);
  endtask

  // Called at a negedge; issues one request and returns at the negedge where
  // ack is seen. With last=0 the caller issues the next request immediately.
  task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input bit last, output logic [31:0] got_rd);
    int l, k, idx;
    bit seen;
    logic [31:0] exp_rd;
    next_lat(sel, l);
    idx = int'((a / 4) % 1024);
    if (ws == 4'h0) exp_rd = mdl[sel][idx];
    else begin
      exp_rd = '0;
      for (int b = 0; b < 4; b++)
        if (ws[b]) mdl[sel][idx][8*b +: 8] = wd[8*b +: 8];
    end
    req[sel]   = 1'b1;
    addr[sel]  = a;
    wdata[sel] = wd;
    wstrb[sel] = ws;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (ack[sel]) seen = 1'b1;
      else begin
        chk("wait_idle", idle[sel], 0);
        drive_garbage(sel);
      end
    end
    chk("latency", k, l);
    got_rd = rdata[sel];
    chk("rdata", rdata[sel], exp_rd);
    if (last) begin
      req[sel]   = 1'b0;
      addr[sel]  = $urandom;
      wstrb[sel] = 4'($urandom);
      #1;
      chk("resp_idle", idle[sel], 1);
      @(negedge clk);
      chk("ack_single", ack[sel], 0);
      chk("rdata_hold", rdata[sel], exp_rd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a, old;
    logic [3:0]  ws;
    int l;
    bit last;
    rst = 1'b0;
    req = '0; addr = '0; wdata = '0; wstrb = '0;
    lfsr_ref[0] = 8'hA5;
    lfsr_ref[1] = 8'hA5;

    do_reset(3);

    // Known contents for the word range exercised below.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++)
        do_op(s, 32'(w * 4), $urandom, 4'hF, 1'b1, rd);

    // Full write then read back.
    do_op(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, rd);
    do_op(0, 32'h10, 32'h0, 4'h0, 1'b1, rd);
    chk("wr_rd", rd, 32'hDEADBEEF);

    // Partial strobe merge.
    do_op(0, 32'h14, 32'hAABBCCDD, 4'hF, 1'b1, rd);
    do_op(0, 32'h14, 32'h11223344, 4'h5, 1'b1, rd);
    do_op(0, 32'h14, 32'h0, 4'h0, 1'b1, rd);
    chk("partial", rd, 32'hAA22CC44);

    // Back-to-back reads, req held high.
    for (int i = 0; i < 4; i++)
      do_op(1, 32'(i * 4), 32'h0, 4'h0, i == 3, rd);

    // Abort a write in WAIT via reset.
    old = mdl[0][8];
    next_lat(0, l);
    req[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678; wstrb[0] = 4'hF;
    @(negedge clk);
    chk("abort_wait_ack", ack[0], 0);
    rst = 1'b0;
    req[0] = 1'b0;
    #1;
    chk("abort_ack", ack[0], 0);
    chk("abort_idle", idle[0], 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lfsr_ref[0] = 8'hA5;
    lfsr_ref[1] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_ack", ack[0], 0);
    end
    do_op(0, 32'h20, 32'h0, 4'h0, 1'b1, rd);
    chk("abort_old", rd, old);

    // Aliasing: upper bits and byte offset ignored.
    do_op(1, 32'hABC0_0007, 32'h5A5A_0001, 4'hF, 1'b1, rd);
    do_op(1, 32'h0000_0004, 32'h0, 4'h0, 1'b1, rd);
    chk("alias", rd, 32'h5A5A_0001);

    // Random mix, sometimes pipelined.
    for (int s = 0; s < 2; s++)
      for (int n = 0; n < 60; n++) begin
        a  = $urandom & 32'hFFFF_F03F;
        ws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        last = ($urandom_range(0, 1) == 0) || (n == 59);
        do_op(s, a, $urandom, ws, last, rd);
      end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
